// File: rtl/mastermind_pkg.sv
// Shared constants, feedback codes and state encoding for the Mastermind scorer.
package mastermind_pkg;

   localparam int unsigned NUM_POS = 4;
   localparam int unsigned COLOR_W = 3;
   localparam int unsigned CNT_W   = 3;

   localparam logic [COLOR_W-1:0] COLOR_EMPTY = '0;

   localparam logic [1:0] FB_MISS  = 2'b00;
   localparam logic [1:0] FB_COLOR = 2'b01;
   localparam logic [1:0] FB_EXACT = 2'b10;

   typedef enum logic [3:0] {
      StIdle    = 4'b0001,
      StExact   = 4'b0010,
      StPartial = 4'b0100,
      StDone    = 4'b1000
   } scorer_state_e;

endpackage

// File: rtl/mastermind_match_find.sv
// Finds the lowest unused target position holding a given color.
module mastermind_match_find #(
   parameter int unsigned NUM_POS = 4,
   parameter int unsigned COLOR_W = 3,
   parameter int unsigned IDX_W   = $clog2(NUM_POS)
) (
   input  logic [COLOR_W-1:0]         color_i,
   input  logic [NUM_POS*COLOR_W-1:0] target_i,
   input  logic [NUM_POS-1:0]         used_i,
   output logic                       found_o,
   output logic [IDX_W-1:0]           idx_o
);

   // Scan from the top so the lowest matching index wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int j = NUM_POS - 1; j >= 0; j--) begin
         if (!used_i[j] && (target_i[j*COLOR_W +: COLOR_W] == color_i)) begin
            found_o = 1'b1;
            idx_o   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: exact pass then partial pass, one position per cycle.
module mastermind_scorer #(
   parameter int unsigned NUM_POS = mastermind_pkg::NUM_POS,
   parameter int unsigned COLOR_W = mastermind_pkg::COLOR_W
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       start,
   input  logic [NUM_POS*COLOR_W-1:0] guess,
   input  logic [NUM_POS*COLOR_W-1:0] target,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 exact_count,
   output logic [2:0]                 color_count,
   output logic [2*NUM_POS-1:0]       pos_feedback,
   output logic                       win
);

   import mastermind_pkg::*;

   localparam int unsigned IDX_W = $clog2(NUM_POS);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_POS - 1);

   scorer_state_e              state_q, state_d;
   logic [NUM_POS*COLOR_W-1:0] guess_q, guess_d;
   logic [NUM_POS*COLOR_W-1:0] target_q, target_d;
   logic [NUM_POS-1:0]         used_q, used_d;
   logic [NUM_POS-1:0]         matched_q, matched_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [CNT_W-1:0]           exact_q, exact_d;
   logic [CNT_W-1:0]           color_q, color_d;
   logic [2*NUM_POS-1:0]       fb_q, fb_d;
   logic                       win_q, win_d;

   logic [COLOR_W-1:0] g_cur;
   logic [COLOR_W-1:0] t_cur;
   logic               find_found;
   logic [IDX_W-1:0]   find_idx;

   assign g_cur = guess_q[idx_q*COLOR_W +: COLOR_W];
   assign t_cur = target_q[idx_q*COLOR_W +: COLOR_W];

   mastermind_match_find #(
      .NUM_POS (NUM_POS),
      .COLOR_W (COLOR_W),
      .IDX_W   (IDX_W)
   ) u_match_find (
      .color_i  (g_cur),
      .target_i (target_q),
      .used_i   (used_q),
      .found_o  (find_found),
      .idx_o    (find_idx)
   );

   always_comb begin
      state_d   = state_q;
      guess_d   = guess_q;
      target_d  = target_q;
      used_d    = used_q;
      matched_d = matched_q;
      idx_d     = idx_q;
      exact_d   = exact_q;
      color_d   = color_q;
      fb_d      = fb_q;
      win_d     = win_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               guess_d   = guess;
               target_d  = target;
               used_d    = '0;
               matched_d = '0;
               idx_d     = '0;
               exact_d   = '0;
               color_d   = '0;
               fb_d      = {NUM_POS{FB_MISS}};
               win_d     = 1'b0;
               state_d   = StExact;
            end
         end
         StExact: begin
            if ((g_cur == t_cur) && (g_cur != COLOR_EMPTY)) begin
               fb_d[idx_q*2 +: 2] = FB_EXACT;
               used_d[idx_q]      = 1'b1;
               matched_d[idx_q]   = 1'b1;
               exact_d            = exact_q + CNT_W'(1);
            end
            if (idx_q == LastIdx) begin
               idx_d   = '0;
               state_d = StPartial;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         StPartial: begin
            // Exact hits already own their target slots via used_q.
            if (!matched_q[idx_q] && (g_cur != COLOR_EMPTY) && find_found) begin
               used_d[find_idx]   = 1'b1;
               fb_d[idx_q*2 +: 2] = FB_COLOR;
               color_d            = color_q + CNT_W'(1);
            end
            if (idx_q == LastIdx) begin
               idx_d   = '0;
               win_d   = (exact_q == CNT_W'(NUM_POS));
               state_d = StDone;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StIdle;
         guess_q   <= '0;
         target_q  <= '0;
         used_q    <= '0;
         matched_q <= '0;
         idx_q     <= '0;
         exact_q   <= '0;
         color_q   <= '0;
         fb_q      <= '0;
         win_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         guess_q   <= guess_d;
         target_q  <= target_d;
         used_q    <= used_d;
         matched_q <= matched_d;
         idx_q     <= idx_d;
         exact_q   <= exact_d;
         color_q   <= color_d;
         fb_q      <= fb_d;
         win_q     <= win_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign exact_count  = exact_q;
   assign color_count  = color_q;
   assign pos_feedback = fb_q;
   assign win          = win_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed self-checking bench for mastermind_scorer.
module tb_mastermind_scorer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [11:0] guess;
   logic [11:0] target;
   logic        busy;
   logic        done;
   logic [2:0]  exact_count;
   logic [2:0]  color_count;
   logic [7:0]  pos_feedback;
   logic        win;

   int tests = 0;
   int fails = 0;

   mastermind_scorer dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (start),
      .guess        (guess),
      .target       (target),
      .busy         (busy),
      .done         (done),
      .exact_count  (exact_count),
      .color_count  (color_count),
      .pos_feedback (pos_feedback),
      .win          (win)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_results(input string tag, input logic [2:0] ex, input logic [2:0] co,
                                input logic [7:0] fb, input logic w);
      check({tag, ":exact"}, 32'(exact_count), 32'(ex));
      check({tag, ":color"}, 32'(color_count), 32'(co));
      check({tag, ":fb"}, 32'(pos_feedback), 32'(fb));
      check({tag, ":win"}, 32'(win), 32'(w));
   endtask

   // Start pulse at edge k; cycles k+1..k+8 must show no done, cycle k+9 must.
   task automatic run_vec(input string tag, input logic [11:0] g, input logic [11:0] t,
                          input logic [2:0] ex, input logic [2:0] co, input logic [7:0] fb,
                          input logic w);
      int dcount;
      guess  = g;
      target = t;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      check({tag, ":busy1"}, 32'(busy), 32'd1);
      dcount = 0;
      for (int c = 1; c < 9; c++) begin
         if (done) dcount++;
         tick();
      end
      check({tag, ":early_done"}, 32'(dcount), 32'd0);
      check({tag, ":done"}, 32'(done), 32'd1);
      check({tag, ":busy9"}, 32'(busy), 32'd1);
      check_results(tag, ex, co, fb, w);
      tick();
      check({tag, ":done_off"}, 32'(done), 32'd0);
      check({tag, ":idle"}, 32'(busy), 32'd0);
      check_results({tag, ":hold"}, ex, co, fb, w);
   endtask

   initial begin
      int dcount;
      int dcyc;

      Reset  = 1'b1;
      start  = 1'b0;
      guess  = '0;
      target = '0;
      tick();
      tick();
      check("rst:busy", 32'(busy), 32'd0);
      check("rst:done", 32'(done), 32'd0);
      check_results("rst", 3'd0, 3'd0, 8'h00, 1'b0);
      Reset = 1'b0;
      tick();

      run_vec("win",      12'o4321, 12'o4321, 3'd4, 3'd0, 8'b10101010, 1'b1);
      run_vec("misplace", 12'o1234, 12'o4321, 3'd0, 3'd4, 8'b01010101, 1'b0);
      run_vec("dup_pair", 12'o2222, 12'o1122, 3'd2, 3'd0, 8'b00001010, 1'b0);
      run_vec("dup_once", 12'o1111, 12'o2213, 3'd1, 3'd0, 8'b00001000, 1'b0);
      run_vec("empty",    12'o0000, 12'o0000, 3'd0, 3'd0, 8'b00000000, 1'b0);
      run_vec("empty_g",  12'o0321, 12'o4321, 3'd3, 3'd0, 8'b00101010, 1'b0);

      // Starts at k+3 (busy) and in the DONE cycle must both be ignored.
      guess  = 12'o1234;
      target = 12'o4321;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      dcount = 0;
      dcyc   = 0;
      for (int c = 1; c <= 12; c++) begin
         if (done) begin
            dcount++;
            dcyc = c;
         end
         start = (c == 3) || (c == 9);
         tick();
      end
      start = 1'b0;
      check("restart:ndone", 32'(dcount), 32'd1);
      check("restart:dcyc", 32'(dcyc), 32'd9);
      check("restart:idle", 32'(busy), 32'd0);
      check_results("restart", 3'd0, 3'd4, 8'b01010101, 1'b0);

      // Reset sampled at edge k+4 aborts the run.
      guess  = 12'o4321;
      target = 12'o4321;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int c = 1; c < 4; c++) tick();
      check("abort:pre_exact", 32'(exact_count), 32'd3);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("abort:busy", 32'(busy), 32'd0);
      check("abort:done", 32'(done), 32'd0);
      check_results("abort", 3'd0, 3'd0, 8'h00, 1'b0);
      dcount = 0;
      for (int c = 0; c < 10; c++) begin
         if (done || busy) dcount++;
         tick();
      end
      check("abort:quiet", 32'(dcount), 32'd0);

      // Inputs changed after capture must not affect the result.
      guess  = 12'o1234;
      target = 12'o4321;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      guess  = 12'o4321;
      target = 12'o0000;
      for (int c = 2; c < 9; c++) tick();
      check("capture:done", 32'(done), 32'd1);
      check_results("capture", 3'd0, 3'd4, 8'b01010101, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
Responder to the mastermind core's guess/check flow. Accepts a submitted guess and the captured target, then computes Mastermind feedback:
- exact hits: right color, right position
- color-only hits: right color, wrong position, with duplicate colors counted correctly
- per-position feedback code for the display

The core starts it on check_guess. It pulses done after a fixed latency and holds its results until the next start.

Parameters:
NUM_POS, 4, code positions per guess (counters sized for NUM_POS=4; other values unsupported)
COLOR_W, 3, bits per color; color value 0 means empty

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only in IDLE
guess  input  NUM_POS*COLOR_W  guess code; position p at bits [p*COLOR_W +: COLOR_W]
target  input  NUM_POS*COLOR_W  secret code, same packing
busy  output  1  high while not in IDLE
done  output  1  one-cycle pulse when results become valid
exact_count  output  3  number of exact hits
color_count  output  3  number of color-only hits
pos_feedback  output  2*NUM_POS  per position: 2'b00 miss, 2'b01 color-only, 2'b10 exact
win  output  1  high when exact_count == NUM_POS

Behaviour:
- Reset is synchronous, active-high on Clk. It forces state IDLE and clears busy, done, exact_count, color_count, pos_feedback, win, internal masks and index.
- Reset overrides everything, including mid-operation: no done pulse and all results are 0 on the following cycle.
- States are one-hot: IDLE, EXACT, PARTIAL, DONE.
- IDLE:
  - When start=1, capture guess and target into internal registers.
  - Clear counts, feedback, win, the target-used mask and the guess-matched mask. Set index=0. Go to EXACT.
  - Inputs are not sampled after capture; later changes to guess/target are ignored.
- EXACT, one position per cycle (4 cycles):
  - If g[index]==t[index] and g[index]!=0: set feedback[index]=EXACT, set used[index] and matched[index], increment exact_count.
  - Go to PARTIAL after index==NUM_POS-1, with index reset to 0.
- PARTIAL, one guess position per cycle (4 cycles):
  - If matched[index]=0 and g[index]!=0, search target positions j=0..NUM_POS-1 combinationally for the lowest j with used[j]=0 and t[j]==g[index].
  - If found: set used[j], set feedback[index]=COLOR, increment color_count.
  - Go to DONE after index==NUM_POS-1.
- DONE, one cycle:
  - done=1; win=(exact_count==NUM_POS); go to IDLE.
- Latency: start sampled at edge k gives EXACT in cycles k+1..k+4, PARTIAL in k+5..k+8, done=1 in cycle k+9. busy=1 from k+1 through k+9.
- Result outputs change only during an operation. They hold after DONE until the next accepted start, which clears them.
- start while busy is ignored entirely, with no queuing. start in the DONE cycle is also ignored.
- Color 0 never matches, exact or partial, even if the target holds 0. A 0 guess position is always a miss.
- Duplicate colors: each target position is consumed at most once. Exact matches consume first, then partial matches are assigned in guess-position order.
- Invariant: exact_count + color_count <= NUM_POS. Counters cannot overflow.

Decomposition:
- Shared package mastermind_pkg holds:
  - NUM_POS, COLOR_W, COLOR_EMPTY=0
  - feedback codes FB_MISS/FB_COLOR/FB_EXACT
  - scorer state encodings
- One sub-module is natural: mastermind_match_find, purely combinational.
  - Inputs: color, target vector, used mask.
  - Outputs: found flag and lowest matching index j.

Test Plan:
- Exact win: target=12'o4321, guess=12'o4321, start pulse → done in cycle k+9; exact=4, color=0, pos_feedback=8'b10101010, win=1.
- All misplaced: target=12'o4321, guess=12'o1234 → exact=0, color=4, pos_feedback=8'b01010101, win=0.
- Duplicate guess against pairs: target=12'o1122, guess=12'o2222 → exact=2, color=0, pos_feedback=8'b00001010.
- Duplicate not over-counted: target=12'o2213, guess=12'o1111 → exact=1 (pos1), color=0, pos_feedback=8'b00001000.
- Empty colors: target=12'o0000, guess=12'o0000 → exact=0, color=0, win=0. Also target=12'o4321, guess=12'o0321 → exact=3, color=0, pos_feedback=8'b00101010.
- Control:
  - Second start pulsed at k+3 → ignored; single done at k+9.
  - New run with Reset=1 at k+4 → next cycle busy=0, all outputs 0, no done.
  - Guess changed at k+2 → results match the guess captured at k.
